// File: rtl/me_search_engine_if.sv
// Host-side bus of the motion-estimation engine: start/config, the two
// synchronous ROM ports and the result outputs.
interface me_search_engine_if #(
    parameter int BLK   = 16,
    parameter int RANGE = 8,
    parameter int PIX_W = 8
);
    localparam int W      = BLK + 2*RANGE;
    localparam int RA_W   = $clog2(BLK*BLK);
    localparam int SA_W   = $clog2(W*W);
    localparam int DIST_W = PIX_W + $clog2(BLK*BLK);
    localparam int MV_W   = $clog2(RANGE+1) + 1;

    logic                     start;
    logic                     early_term_en;
    logic [DIST_W-1:0]        dist_limit;
    logic [RA_W-1:0]          AddressR;
    logic [PIX_W-1:0]         R;
    logic [SA_W-1:0]          AddressS;
    logic [PIX_W-1:0]         S;
    logic [DIST_W-1:0]        BestDist;
    logic signed [MV_W-1:0]   motionX;
    logic signed [MV_W-1:0]   motionY;
    logic                     busy;
    logic                     completed;

    // Host: issues start/config and serves both ROMs.
    modport master (
        output start, early_term_en, dist_limit, R, S,
        input  AddressR, AddressS, BestDist, motionX, motionY, busy, completed
    );

    // Engine side.
    modport slave (
        input  start, early_term_en, dist_limit, R, S,
        output AddressR, AddressS, BestDist, motionX, motionY, busy, completed
    );
endinterface

// File: rtl/me_search_engine.sv
// Full-search block-matching motion estimator. Walks every candidate
// displacement in raster order, accumulates the SAD over the block with one
// pixel pair per cycle, and reports the minimum SAD and its vector.
// Optional early termination aborts hopeless candidates and exits once the
// best SAD is at or below a caller-supplied threshold.
module me_search_engine #(
    parameter int BLK   = 16,
    parameter int RANGE = 8,
    parameter int PIX_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    me_search_engine_if.slave bus
);
    localparam int W      = BLK + 2*RANGE;
    localparam int NPIX   = BLK*BLK;
    localparam int RA_W   = $clog2(BLK*BLK);
    localparam int SA_W   = $clog2(W*W);
    localparam int DIST_W = PIX_W + $clog2(BLK*BLK);
    localparam int MV_W   = $clog2(RANGE+1) + 1;
    localparam int CW     = $clog2(BLK);
    localparam int OW     = $clog2(2*RANGE+1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CMP, S_DONE} state_t;

    state_t              r_state;
    logic [RA_W-1:0]     r_addr_r;     // doubles as the pixel index of the current read
    logic [SA_W-1:0]     r_addr_s;
    logic [CW-1:0]       r_i, r_j;
    logic [OW-1:0]       r_ox, r_oy;   // candidate offsets biased by +RANGE
    logic [OW-1:0]       r_bx, r_by;   // offsets of the best candidate so far
    logic [DIST_W-1:0]   r_acc;
    logic [DIST_W-1:0]   r_best;
    logic                r_et;
    logic [DIST_W-1:0]   r_limit;
    logic [DIST_W-1:0]   r_best_dist;
    logic [MV_W-1:0]     r_mvx, r_mvy;
    logic                r_busy, r_completed;

    logic [PIX_W-1:0]    w_diff;
    logic [DIST_W-1:0]   w_acc_nxt;
    logic [DIST_W-1:0]   w_best_cmp;
    logic                w_last_cand;
    logic [CW-1:0]       w_i_nxt, w_j_nxt;
    logic [OW-1:0]       w_ox_nxt, w_oy_nxt;

    // Window address of pixel (i,j) for the candidate at biased offset (ox,oy).
    function automatic logic [SA_W-1:0] f_addr_s(input logic [CW-1:0] i, input logic [CW-1:0] j,
                                                 input logic [OW-1:0] oy, input logic [OW-1:0] ox);
        return SA_W'((int'(i) + int'(oy)) * W + int'(j) + int'(ox));
    endfunction

    // Pixel difference, running SAD and next pixel / candidate counters.
    always_comb begin
        w_diff      = (bus.R > bus.S) ? bus.R - bus.S : bus.S - bus.R;
        w_acc_nxt   = r_acc + DIST_W'(w_diff);
        w_best_cmp  = (r_acc < r_best) ? r_acc : r_best;
        w_last_cand = (r_ox == OW'(2*RANGE)) && (r_oy == OW'(2*RANGE));
        w_j_nxt     = (r_j == CW'(BLK-1)) ? '0 : r_j + CW'(1);
        w_i_nxt     = (r_j == CW'(BLK-1)) ? r_i + CW'(1) : r_i;
        w_ox_nxt    = (r_ox == OW'(2*RANGE)) ? '0 : r_ox + OW'(1);
        w_oy_nxt    = (r_ox == OW'(2*RANGE)) ? r_oy + OW'(1) : r_oy;
    end

    // Search sequencer: addresses, accumulation, best tracking, result latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_addr_r    <= '0;
            r_addr_s    <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_bx        <= '0;
            r_by        <= '0;
            r_acc       <= '0;
            r_best      <= '1;
            r_et        <= 1'b0;
            r_limit     <= '0;
            r_best_dist <= '1;
            r_mvx       <= '0;
            r_mvy       <= '0;
            r_busy      <= 1'b0;
            r_completed <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_et        <= bus.early_term_en;
                        r_limit     <= bus.dist_limit;
                        r_best      <= '1;
                        r_acc       <= '0;
                        r_ox        <= '0;
                        r_oy        <= '0;
                        r_bx        <= '0;
                        r_by        <= '0;
                        r_i         <= '0;
                        r_j         <= '0;
                        r_addr_r    <= '0;
                        r_addr_s    <= '0;
                        r_busy      <= 1'b1;
                        r_completed <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Data of the previous address is on R/S from the second cycle on.
                    if (r_addr_r != '0)
                        r_acc <= w_acc_nxt;
                    if (r_et && (r_addr_r != '0) && (w_acc_nxt >= r_best)) begin
                        r_state <= S_CMP;
                    end else if (r_addr_r == RA_W'(NPIX-1)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr_r <= r_addr_r + RA_W'(1);
                        r_i      <= w_i_nxt;
                        r_j      <= w_j_nxt;
                        r_addr_s <= f_addr_s(w_i_nxt, w_j_nxt, r_oy, r_ox);
                    end
                end
                S_DRAIN: begin
                    // Last pixel; an abort here lands in CMP anyway.
                    r_acc   <= w_acc_nxt;
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    r_acc <= '0;
                    if (r_acc < r_best) begin
                        r_best <= r_acc;
                        r_bx   <= r_ox;
                        r_by   <= r_oy;
                    end
                    if (w_last_cand || (r_et && (w_best_cmp <= r_limit))) begin
                        r_state <= S_DONE;
                    end else begin
                        r_ox     <= w_ox_nxt;
                        r_oy     <= w_oy_nxt;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_addr_r <= '0;
                        r_addr_s <= f_addr_s('0, '0, w_oy_nxt, w_ox_nxt);
                        r_state  <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_best_dist <= r_best;
                    r_mvx       <= MV_W'(r_bx) - MV_W'(RANGE);
                    r_mvy       <= MV_W'(r_by) - MV_W'(RANGE);
                    r_busy      <= 1'b0;
                    r_completed <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.AddressR  = r_addr_r;
    assign bus.AddressS  = r_addr_s;
    assign bus.BestDist  = r_best_dist;
    assign bus.motionX   = r_mvx;
    assign bus.motionY   = r_mvy;
    assign bus.busy      = r_busy;
    assign bus.completed = r_completed;
endmodule

// File: tb/tb_me_search_engine.sv
// Directed bench for me_search_engine at BLK=4, RANGE=2. A search-level model
// (min SAD over all candidates plus per-candidate cycle cost) predicts the
// result and busy duration; literal expectations pin the model.
module tb_me_search_engine;
    localparam int BLK = 4, RANGE = 2, PIX_W = 8;
    localparam int W = BLK + 2*RANGE;
    localparam int NPIX = BLK*BLK;

    logic clock, reset_n;
    me_search_engine_if #(.BLK(BLK), .RANGE(RANGE), .PIX_W(PIX_W)) bus();

    me_search_engine #(.BLK(BLK), .RANGE(RANGE), .PIX_W(PIX_W)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    logic [7:0] rom_r [NPIX];
    logic [7:0] rom_s [W*W];

    int n_checks = 0, n_pass = 0;
    int exp_dist, exp_mx, exp_my, exp_cycles;
    bit mon_en = 0;

    initial clock = 0;
    always #5 clock = ~clock;

    // Synchronous ROMs: one-cycle read latency.
    always @(posedge clock) begin
        bus.R <= rom_r[bus.AddressR];
        bus.S <= rom_s[bus.AddressS];
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Search-level model: exhaustive SAD, strict-min, good-enough exit, and
    // the cycle cost of each candidate (full = NPIX+2, abort after pixel p = p+3).
    task automatic model(input bit et, input int lim);
        int best, acc, cost, a, b;
        bit stop, aborted;
        best = 4095; exp_mx = -RANGE; exp_my = -RANGE; exp_cycles = 1; stop = 0;
        for (int dy = -RANGE; dy <= RANGE && !stop; dy++)
            for (int dx = -RANGE; dx <= RANGE && !stop; dx++) begin
                acc = 0; cost = NPIX + 2; aborted = 0;
                for (int p = 0; p < NPIX; p++) begin
                    a = rom_r[p];
                    b = rom_s[(p/BLK + dy + RANGE)*W + (p%BLK) + dx + RANGE];
                    acc += (a > b) ? a - b : b - a;
                    if (et && acc >= best) begin cost = p + 3; aborted = 1; break; end
                end
                exp_cycles += cost;
                if (!aborted && acc < best) begin best = acc; exp_mx = dx; exp_my = dy; end
                if (et && best <= lim) stop = 1;
            end
        exp_dist = best;
    endtask

    // Result outputs must hold the model result every cycle completed is high.
    always @(negedge clock) begin
        if (mon_en && reset_n && bus.completed) begin
            check("mon_dist", bus.BestDist, exp_dist);
            check("mon_mx", $signed(bus.motionX), exp_mx);
            check("mon_my", $signed(bus.motionY), exp_my);
            check("mon_busy", bus.busy, 0);
        end
    end

    task automatic fill_random_r;
        for (int k = 0; k < NPIX; k++) rom_r[k] = 8'(7 + 13*k);
        for (int k = 0; k < W*W; k++) rom_s[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic place_copy(input int dx, input int dy);
        for (int p = 0; p < NPIX; p++)
            rom_s[(p/BLK + dy + RANGE)*W + (p%BLK) + dx + RANGE] = rom_r[p];
    endtask

    // Start a search and count busy cycles; optionally pulse start mid-search.
    task automatic run_search(input string tag, input bit et, input int lim,
                              input int pulse_at, output int cyc);
        mon_en = 0;
        model(et, lim);
        @(negedge clock);
        bus.start = 1; bus.early_term_en = et; bus.dist_limit = 12'(lim);
        @(negedge clock);
        bus.start = 0; bus.early_term_en = 0; bus.dist_limit = '0;
        mon_en = 1;
        cyc = 0;
        while (bus.busy && cyc < 2000) begin
            cyc++;
            @(negedge clock);
            bus.start = (cyc == pulse_at) ? 1'b1 : 1'b0;
        end
        bus.start = 0;
        check({tag, "_no_timeout"}, (cyc < 2000) ? 1 : 0, 1);
        check({tag, "_busy_cycles"}, cyc, exp_cycles);
        check({tag, "_completed"}, bus.completed, 1);
    endtask

    task automatic reset_mid(input string tag, input int after);
        repeat (after) @(negedge clock);
        check({tag, "_busy_before_rst"}, bus.busy, 1);
        mon_en = 0;
        reset_n = 0;
        #1;
        check({tag, "_rst_dist"}, bus.BestDist, 4095);
        check({tag, "_rst_mx"}, bus.motionX, 0);
        check({tag, "_rst_my"}, bus.motionY, 0);
        check({tag, "_rst_busy"}, bus.busy, 0);
        check({tag, "_rst_completed"}, bus.completed, 0);
        check({tag, "_rst_addr"}, {bus.AddressR, bus.AddressS}, 0);
        @(negedge clock);
        reset_n = 1;
    endtask

    initial begin
        int cyc;
        reset_n = 0;
        bus.start = 0; bus.early_term_en = 0; bus.dist_limit = '0;
        for (int k = 0; k < NPIX; k++) rom_r[k] = 8'd255;
        for (int k = 0; k < W*W; k++) rom_s[k] = 8'd0;
        repeat (3) @(negedge clock);
        check("init_dist", bus.BestDist, 4095);
        check("init_busy", bus.busy, 0);
        check("init_completed", bus.completed, 0);
        reset_n = 1;

        // 1: reset in the middle of a search
        @(negedge clock); bus.start = 1;
        @(negedge clock); bus.start = 0;
        reset_mid("t1", 30);

        // 2: unique exact copy at (+1,-2)
        fill_random_r();
        place_copy(1, -2);
        run_search("t2", 0, 0, -1, cyc);
        check("t2_model_dist", exp_dist, 0);
        check("t2_model_mx", exp_mx, 1);
        check("t2_dist", bus.BestDist, 0);
        check("t2_mx", $signed(bus.motionX), 1);
        check("t2_my", $signed(bus.motionY), -2);
        check("t2_busy_lit", cyc, 451);
        repeat (6) @(negedge clock);
        check("t2_completed_hold", bus.completed, 1);

        // 3: tie between (-2,-2) and (+2,+2); first in raster order wins
        fill_random_r();
        place_copy(-2, -2);
        place_copy(2, 2);
        run_search("t3", 0, 0, -1, cyc);
        check("t3_dist", bus.BestDist, 0);
        check("t3_mx", $signed(bus.motionX), -2);
        check("t3_my", $signed(bus.motionY), -2);

        // 4: maximal SAD everywhere
        for (int k = 0; k < NPIX; k++) rom_r[k] = 8'd255;
        for (int k = 0; k < W*W; k++) rom_s[k] = 8'd0;
        run_search("t4", 0, 0, -1, cyc);
        check("t4_model_dist", exp_dist, 4080);
        check("t4_dist", bus.BestDist, 4080);
        check("t4_mx", $signed(bus.motionX), -2);
        check("t4_my", $signed(bus.motionY), -2);

        // 5: early termination with a perfect match at candidate 12
        fill_random_r();
        place_copy(0, 0);
        run_search("t5", 1, 0, -1, cyc);
        check("t5_dist", bus.BestDist, 0);
        check("t5_mx", $signed(bus.motionX), 0);
        check("t5_my", $signed(bus.motionY), 0);
        check("t5_busy_bound", (cyc < 235) ? 1 : 0, 1);

        // 6: start pulsed while busy is ignored, then reset mid-RUN
        fill_random_r();
        place_copy(1, -2);
        run_search("t6", 0, 0, 100, cyc);
        check("t6_dist", bus.BestDist, 0);
        check("t6_mx", $signed(bus.motionX), 1);
        check("t6_my", $signed(bus.motionY), -2);
        @(negedge clock); bus.start = 1;
        @(negedge clock); bus.start = 0;
        reset_mid("t6", 10);
        run_search("t6b", 0, 0, -1, cyc);
        check("t6b_dist", bus.BestDist, 0);
        check("t6b_mx", $signed(bus.motionX), 1);

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
